sram_like_arbiter: RTL and testbench

- Shares one sram-like slave port (the path to the cache/AXI bridge) between two sram-like masters: instruction fetch (m0) and the execute-stage data port (m1).
- Data requests have fixed priority over fetch.
- Multiple accepted requests may be in flight. A small in-order ID FIFO records which master owns each accepted request, so that every data_ok/rdata is routed back to the correct master.

---
 rtl/sram_like_arbiter.sv | 120 ++++++++++++
 tb/tb_sram_like_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// Two-master sram-like arbiter: data port has priority over fetch,
// with an in-order ID FIFO steering responses back to their owner.
module sram_like_arbiter #(
   parameter int MAX_OUTST = 2,
   parameter int ID_PTR_W  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic        m0_wr,
   input  logic [1:0]  m0_size,
   input  logic [31:0] m0_addr,
   input  logic [3:0]  m0_wstrb,
   input  logic [31:0] m0_wdata,
   output logic        m0_addr_ok,
   output logic        m0_data_ok,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_wr,
   input  logic [1:0]  m1_size,
   input  logic [31:0] m1_addr,
   input  logic [3:0]  m1_wstrb,
   input  logic [31:0] m1_wdata,
   output logic        m1_addr_ok,
   output logic        m1_data_ok,
   output logic [31:0] m1_rdata,
   output logic        s_req,
   output logic        s_wr,
   output logic [1:0]  s_size,
   output logic [31:0] s_addr,
   output logic [3:0]  s_wstrb,
   output logic [31:0] s_wdata,
   input  logic        s_addr_ok,
   input  logic        s_data_ok,
   input  logic [31:0] s_rdata
);

   localparam int CNT_W = $clog2(MAX_OUTST + 1);

   logic                 lock_valid;
   logic                 lock_id;
   logic                 grant;
   logic                 accept;
   logic                 pop;
   logic                 head;
   logic [MAX_OUTST-1:0] id_fifo;
   logic [ID_PTR_W-1:0]  rd_ptr;
   logic [ID_PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]     count;

   function automatic logic [ID_PTR_W-1:0] inc(input logic [ID_PTR_W-1:0] p);
      return (p == ID_PTR_W'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
   endfunction

   // A locked grant keeps the payload stable until the slave takes it.
   always_comb begin
      grant   = lock_valid ? lock_id : m1_req;
      s_req   = (m0_req | m1_req) & (count < CNT_W'(MAX_OUTST)) & ~reset;
      s_wr    = 1'b0;
      s_size  = '0;
      s_addr  = '0;
      s_wstrb = '0;
      s_wdata = '0;
      if (s_req) begin
         if (grant) begin
            s_wr    = m1_wr;
            s_size  = m1_size;
            s_addr  = m1_addr;
            s_wstrb = m1_wstrb;
            s_wdata = m1_wdata;
         end else begin
            s_wr    = m0_wr;
            s_size  = m0_size;
            s_addr  = m0_addr;
            s_wstrb = m0_wstrb;
            s_wdata = m0_wdata;
         end
      end
   end

   assign accept     = s_req & s_addr_ok;
   assign m1_addr_ok = accept & grant;
   assign m0_addr_ok = accept & ~grant;

   // Stray responses with nothing outstanding are dropped.
   assign head       = id_fifo[rd_ptr];
   assign pop        = s_data_ok & (count != '0) & ~reset;
   assign m1_data_ok = pop & head;
   assign m0_data_ok = pop & ~head;
   assign m0_rdata   = reset ? '0 : s_rdata;
   assign m1_rdata   = reset ? '0 : s_rdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         lock_valid <= 1'b0;
         lock_id    <= 1'b0;
         id_fifo    <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
      end else begin
         if (accept) begin
            lock_valid      <= 1'b0;
            id_fifo[wr_ptr] <= grant;
            wr_ptr          <= inc(wr_ptr);
         end else if (s_req) begin
            lock_valid <= 1'b1;
            lock_id    <= grant;
         end
         if (pop)
            rd_ptr <= inc(rd_ptr);
         case ({accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Scoreboard bench for sram_like_arbiter: stimulus queues expected
// addr_ok/data_ok events, a negedge monitor pops and compares them.
module tb_sram_like_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_wr, m1_req, m1_wr;
   logic [1:0]  m0_size, m1_size;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
   logic [31:0] m0_rdata, m1_rdata;
   logic        s_req, s_wr, s_addr_ok, s_data_ok;
   logic [1:0]  s_size;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  s_wstrb;

   typedef struct {
      logic        id;
      logic [31:0] val;
   } exp_t;

   exp_t aq[$];
   exp_t dq[$];
   int   checks = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   sram_like_arbiter #(.MAX_OUTST(2), .ID_PTR_W(1)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size),
      .m0_addr(m0_addr), .m0_wstrb(m0_wstrb), .m0_wdata(m0_wdata),
      .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok),
      .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size),
      .m1_addr(m1_addr), .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata),
      .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok),
      .m1_rdata(m1_rdata),
      .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
      .s_wstrb(s_wstrb), .s_wdata(s_wdata),
      .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata)
   );

   function automatic void chk(string nm, logic [31:0] act,
                               logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (m0_addr_ok | m1_addr_ok) begin
            chk("addr_ok_pending", 32'(aq.size() > 0), 32'd1);
            if (aq.size() > 0) begin
               e = aq.pop_front();
               chk("addr_ok_who", {30'b0, m1_addr_ok, m0_addr_ok},
                   e.id ? 32'd2 : 32'd1);
               chk("s_addr", s_addr, e.val);
            end
         end
         if (m0_data_ok | m1_data_ok) begin
            chk("data_ok_pending", 32'(dq.size() > 0), 32'd1);
            if (dq.size() > 0) begin
               e = dq.pop_front();
               chk("data_ok_who", {30'b0, m1_data_ok, m0_data_ok},
                   e.id ? 32'd2 : 32'd1);
               chk("rdata", e.id ? m1_rdata : m0_rdata, e.val);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      m0_req = 0; m0_wr = 0; m0_size = 2'd2; m0_addr = '0;
      m0_wstrb = '0; m0_wdata = '0;
      m1_req = 0; m1_wr = 0; m1_size = 2'd2; m1_addr = '0;
      m1_wstrb = '0; m1_wdata = '0;
      s_addr_ok = 0; s_data_ok = 0; s_rdata = '0;
   endtask

   task automatic push_a(input logic id, input logic [31:0] v);
      aq.push_back('{id: id, val: v});
   endtask

   task automatic data(input logic id, input logic [31:0] v);
      s_data_ok = 1; s_rdata = v;
      dq.push_back('{id: id, val: v});
   endtask

   initial begin
      idle();
      reset = 1;
      m0_req = 1; m1_req = 1; m1_addr = 32'h1234;
      s_addr_ok = 1; s_data_ok = 1; s_rdata = 32'hFFFF_FFFF;
      step();
      step();
      #2;
      chk("rst_s_req", {31'b0, s_req}, 0);
      chk("rst_addr_ok", {30'b0, m1_addr_ok, m0_addr_ok}, 0);
      chk("rst_data_ok", {30'b0, m1_data_ok, m0_data_ok}, 0);
      chk("rst_s_addr", s_addr, 0);
      chk("rst_rdata", m0_rdata | m1_rdata, 0);
      idle();
      reset = 0;
      step();

      // single fetch
      m0_req = 1; m0_addr = 32'hBFC0_0000; s_addr_ok = 1;
      push_a(0, 32'hBFC0_0000);
      step();
      idle();
      step();
      data(0, 32'h3C1D_BFC0);
      step();
      idle();
      step();

      // priority
      m0_req = 1; m0_addr = 32'h1000;
      m1_req = 1; m1_addr = 32'h2000; s_addr_ok = 1;
      push_a(1, 32'h2000);
      step();
      m1_req = 0;
      push_a(0, 32'h1000);
      step();
      idle();
      data(1, 32'hA1);
      step();
      data(0, 32'hA2);
      step();
      idle();
      step();

      // lock holds m0 against a late m1
      m0_req = 1; m0_addr = 32'h3000;
      #2 chk("lock_c1", s_addr, 32'h3000);
      step();
      m1_req = 1; m1_addr = 32'h4000; m1_wr = 1;
      m1_wstrb = 4'hF; m1_wdata = 32'hCAFE_F00D;
      #2 chk("lock_c2", s_addr, 32'h3000);
      step();
      #2 chk("lock_c3", s_addr, 32'h3000);
      step();
      s_addr_ok = 1;
      push_a(0, 32'h3000);
      step();
      m0_req = 0;
      push_a(1, 32'h4000);
      #2;
      chk("m1_wr", {31'b0, s_wr}, 1);
      chk("m1_wdata", s_wdata, 32'hCAFE_F00D);
      chk("m1_wstrb", {28'b0, s_wstrb}, 32'hF);
      step();
      idle();
      data(0, 32'hB0);
      step();
      data(1, 32'hB1);
      step();
      idle();
      step();

      // full and in-order return, then push/pop at count 1
      m1_req = 1; m1_addr = 32'h5000; s_addr_ok = 1;
      push_a(1, 32'h5000);
      step();
      m1_req = 0; m0_req = 1; m0_addr = 32'h6000;
      push_a(0, 32'h6000);
      step();
      m0_req = 0; m1_req = 1; m1_addr = 32'h7000;
      #2;
      chk("full_s_req", {31'b0, s_req}, 0);
      chk("full_s_addr", s_addr, 0);
      step();
      data(1, 32'h11);
      #2 chk("full_s_req2", {31'b0, s_req}, 0);
      step();
      data(0, 32'h22);
      push_a(1, 32'h7000);
      #2 chk("reissue_s_req", {31'b0, s_req}, 1);
      step();
      m1_req = 0; s_addr_ok = 0;
      data(1, 32'h33);
      #2 chk("idle_s_req", {31'b0, s_req}, 0);
      step();
      idle();
      step();

      // simultaneous push/pop at count 1
      m0_req = 1; m0_addr = 32'h8000; s_addr_ok = 1;
      push_a(0, 32'h8000);
      step();
      m0_req = 0; m1_req = 1; m1_addr = 32'h9000;
      push_a(1, 32'h9000);
      data(0, 32'h44);
      step();
      m1_req = 0; s_addr_ok = 0;
      data(1, 32'h55);
      step();
      idle();
      step();

      // reset with two outstanding, then a stray response
      m1_req = 1; m1_addr = 32'hA000; s_addr_ok = 1;
      push_a(1, 32'hA000);
      step();
      m1_req = 0; m0_req = 1; m0_addr = 32'hB000;
      push_a(0, 32'hB000);
      step();
      idle();
      reset = 1;
      step();
      reset = 0;
      s_data_ok = 1; s_rdata = 32'hDEAD;
      #2 chk("stray_data_ok", {30'b0, m1_data_ok, m0_data_ok}, 0);
      step();
      idle();
      m0_req = 1; m0_addr = 32'hC000; s_addr_ok = 1;
      push_a(0, 32'hC000);
      step();
      idle();
      data(0, 32'h66);
      step();
      idle();
      repeat (3) step();

      chk("addr_q_drained", aq.size(), 0);
      chk("data_q_drained", dq.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
